booth_mult_arbiter: RTL and testbench

BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

---
 rtl/booth_mult_arbiter.sv | 137 +++++++++++++
 tb/tb_booth_mult_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: two-requester front end sharing one radix-2 Booth
// sequential multiplier. One product per WIDTH+2 cycles.
// Build option: BOOTH_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default build uses fixed priority, requester 0 first).
module booth_mult_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_prod,
   output logic               res_id
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t            state_q, state_d;
   logic              gnt0, gnt1;
   // Accumulator carries one guard bit so that A-M with M = most negative
   // value cannot wrap; the product is taken from its low WIDTH bits.
   logic [WIDTH:0]    acc_q, acc_d;
   logic [WIDTH:0]    m_q;
   logic [WIDTH:0]    sum;
   logic [WIDTH-1:0]  q_q, q_d;
   logic              qm1_q, qm1_d;
   logic [CW-1:0]     cnt_q;
   logic              id_q;
`ifdef BOOTH_ARB_ROUND_ROBIN_EN
   logic              ptr_q;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt0 || gnt1) state_d = ITER;
         ITER:    if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: grant decision (only in IDLE) and result handshake
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE && !rst) begin
`ifdef BOOTH_ARB_ROUND_ROBIN_EN
         if (req0_valid && req1_valid) begin
            gnt0 = ~ptr_q;
            gnt1 = ptr_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
`else
         gnt0 = req0_valid;
         gnt1 = req1_valid && !req0_valid;
`endif
      end
      req0_ready = gnt0;
      req1_ready = gnt1;
      res_valid  = (state_q == DONE) && !rst;
      res_prod   = {acc_q[WIDTH-1:0], q_q};
      res_id     = id_q;
   end

   // One Booth step: add/subtract on {Q0,Q-1}, then arithmetic shift right
   always_comb begin
      case ({q_q[0], qm1_q})
         2'b01:   sum = acc_q + m_q;
         2'b10:   sum = acc_q - m_q;
         default: sum = acc_q;
      endcase
      acc_d = {sum[WIDTH], sum[WIDTH:1]};
      q_d   = {sum[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
   end

   // Datapath registers: load on grant, step while iterating
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         m_q   <= '0;
         q_q   <= '0;
         qm1_q <= 1'b0;
         cnt_q <= '0;
         id_q  <= 1'b0;
      end else if (state_q == IDLE) begin
         if (gnt0 || gnt1) begin
            acc_q <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            id_q  <= gnt1;
            if (gnt1) begin
               m_q <= {req1_a[WIDTH-1], req1_a};
               q_q <= req1_b;
            end else begin
               m_q <= {req0_a[WIDTH-1], req0_a};
               q_q <= req0_b;
            end
         end
      end else if (state_q == ITER) begin
         acc_q <= acc_d;
         q_q   <= q_d;
         qm1_q <= qm1_d;
         cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef BOOTH_ARB_ROUND_ROBIN_EN
   // Round-robin pointer: favour the requester not granted last
   always_ff @(posedge clk) begin
      if (rst)       ptr_q <= 1'b0;
      else if (gnt0) ptr_q <= 1'b1;
      else if (gnt1) ptr_q <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter (WIDTH=8): vector table,
// hand-written corner sequences and randomized transactions against a
// plain-arithmetic reference model.
module tb_booth_mult_arbiter;

   localparam int W = 8;

   logic          clk, rst;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          res_valid, res_ready, res_id;
   logic [2*W-1:0] res_prod;

   int  checks   = 0;
   int  failures = 0;
   logic pref    = 1'b0;   // model: requester favoured on a tie

   booth_mult_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_prod(res_prod), .res_id(res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v0, v1;
      logic [7:0] a0, b0, a1, b1;
      logic       eid;
      logic [15:0] ep;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference arbitration rule
   function automatic logic model_gnt(input logic v0, input logic v1);
      if (v0 && v1) begin
`ifdef BOOTH_ARB_ROUND_ROBIN_EN
         return pref;
`else
         return 1'b0;
`endif
      end
      return !v0;
   endfunction

   // Reference product: plain signed multiplication
   function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
      int sa, sb, p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[15:0];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      pref = 1'b0;
   endtask

   // From posedge+1 after the accepting edge: count edges until res_valid,
   // scribbling operand buses and watching that no ready is raised.
   task automatic wait_valid(output int lat, output logic quiet);
      lat = 0;
      quiet = 1'b1;
      while (res_valid !== 1'b1 && lat < 40) begin
         if (req0_ready || req1_ready) quiet = 1'b0;
         req0_a = 8'($urandom); req0_b = 8'($urandom);
         req1_a = 8'($urandom); req1_b = 8'($urandom);
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   // One full transaction starting in an IDLE cycle at posedge+1.
   task automatic xact(input logic v0, input logic v1,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input logic eid, input logic [15:0] ep,
                       input int hold, input string nm);
      int lat;
      logic quiet, stable, i0;
      logic [15:0] p0;
      req0_valid = v0; req1_valid = v1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      res_ready = 1'b0;
      @(negedge clk);
      chk({nm, ".grant"}, {30'b0, req1_ready, req0_ready}, eid ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      pref = ~eid;
      wait_valid(lat, quiet);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk({nm, ".latency"}, lat, W);
      chk({nm, ".holdoff"}, {31'b0, quiet}, 32'd1);
      chk({nm, ".prod"}, {16'b0, res_prod}, {16'b0, ep});
      chk({nm, ".id"}, {31'b0, res_id}, {31'b0, eid});
      p0 = res_prod; i0 = res_id; stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b1 || res_prod !== p0 || res_id !== i0 ||
             req0_ready || req1_ready) stable = 1'b0;
      end
      if (hold > 0) chk({nm, ".stable"}, {31'b0, stable}, 32'd1);
      handshake();
      chk({nm, ".released"}, {31'b0, res_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      logic quiet, stable, eid, v0, v1;
      logic [7:0] a0, b0, a1, b1;
      logic [15:0] p0;

      tbl[0] = '{1'b1, 1'b0, 8'h03, 8'hFC, 8'h00, 8'h00, 1'b0, 16'hFFF4};
      tbl[1] = '{1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 16'h4000};
      tbl[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h7F, 8'h80, 1'b1, 16'hC080};
      tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 16'h0000};
      tbl[4] = '{1'b1, 1'b1, 8'h05, 8'h06, 8'hF9, 8'h09, 1'b0, 16'h001E};
`ifdef BOOTH_ARB_ROUND_ROBIN_EN
      tbl[5] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'h64, 8'hFD, 1'b1, 16'hFED4};
`else
      tbl[5] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'h64, 8'hFD, 1'b0, 16'h0001};
`endif
      tbl[6] = '{1'b1, 1'b1, 8'h02, 8'h80, 8'h80, 8'h7F, 1'b0, 16'hFF00};
      tbl[7] = '{1'b1, 1'b0, 8'h7F, 8'h7F, 8'h00, 8'h00, 1'b0, 16'h3F01};

      // Reset state, with both requesters asserting during reset
      rst = 1'b1; res_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h33; req1_b = 8'h44;
      @(negedge clk);
      chk("rst.readies", {30'b0, req1_ready, req0_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rst.valid", {31'b0, res_valid}, 32'd0);
      chk("rst.prod", {16'b0, res_prod}, 32'd0);
      chk("rst.id", {31'b0, res_id}, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1 rst = 1'b0;
      pref = 1'b0;
      @(posedge clk); #1;

      // Vector table, back-to-back
      for (int i = 0; i < 8; i++)
         xact(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
              tbl[i].eid, tbl[i].ep, i % 3, $sformatf("tbl%0d", i));

      // Result held 20 cycles with both requesters waiting
      do_reset();
      req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'hFC;
      req1_valid = 1'b1; req1_a = 8'h0A; req1_b = 8'h0B;
      @(negedge clk);
      chk("hold.grant1", {30'b0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); #1;
      pref = 1'b1;
      wait_valid(lat, quiet);
      chk("hold.latency", lat, W);
      chk("hold.prod", {16'b0, res_prod}, 32'h0000FFF4);
      p0 = res_prod; stable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b1 || res_prod !== p0 || res_id !== 1'b0 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
      end
      chk("hold.stable", {31'b0, stable}, 32'd1);
      handshake();
      req0_a = 8'hFD; req0_b = 8'h05; req1_a = 8'h06; req1_b = 8'hFA;
      chk("hold.released", {31'b0, res_valid}, 32'd0);
      eid = model_gnt(1'b1, 1'b1);
      @(negedge clk);
      chk("hold.grant2", {30'b0, req1_ready, req0_ready}, eid ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      pref = ~eid;
      wait_valid(lat, quiet);
      chk("hold.prod2", {16'b0, res_prod}, eid ? 32'h0000FFDC : 32'h0000FFF1);
      chk("hold.id2", {31'b0, res_id}, {31'b0, eid});
      handshake();

      // Reset in the middle of an iteration aborts it
      do_reset();
      req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h09;
      @(negedge clk);
      chk("abort.grant", {30'b0, req1_ready, req0_ready}, 32'd2);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pref = 1'b0;
      chk("abort.valid", {31'b0, res_valid}, 32'd0);
      chk("abort.prod", {16'b0, res_prod}, 32'd0);
      chk("abort.id", {31'b0, res_id}, 32'd0);
      quiet = 1'b1;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b0) quiet = 1'b0;
      end
      chk("abort.noresult", {31'b0, quiet}, 32'd1);
      xact(1'b1, 1'b0, 8'hFB, 8'h07, 8'h00, 8'h00, 1'b0, 16'hFFDD, 0, "abort.fresh");

      // Randomized transactions against the reference model
      do_reset();
      for (int i = 0; i < 30; i++) begin
         v0 = 1'($urandom); v1 = 1'($urandom);
         if (!v0 && !v1) v1 = 1'b1;
         a0 = 8'($urandom); b0 = 8'($urandom);
         a1 = 8'($urandom); b1 = 8'($urandom);
         if (i == 0) begin a0 = 8'h80; b0 = 8'h7F; end
         eid = model_gnt(v0, v1);
         xact(v0, v1, a0, b0, a1, b1, eid,
              eid ? model_prod(a1, b1) : model_prod(a0, b0),
              int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
